// File: rtl/ifu_if.sv
// Instruction-memory fetch bus: valid/ready request, valid-qualified response.
interface ifu_if;
    localparam int unsigned XLEN = 32;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_resp_valid;
    logic            mem_resp_err;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req_valid,
        output mem_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_err,
        input  mem_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_err,
        output mem_rdata
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: single outstanding fetch, PC advanced only by the
// retire path, sticky fault on bus error or misaligned next PC.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic         clock,
    input  logic         reset_n,
    ifu_if.master        mem,
    output logic         inst_valid,
    output logic [31:0]  inst,
    output logic [31:0]  pc,
    input  logic         pc_next_valid,
    input  logic [31:0]  pc_next,
    output logic         fault,
    output logic [31:0]  fetch_cnt
);
    localparam int unsigned XLEN     = 32;
    localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_nx;
    logic [XLEN-1:0] pc_nx;
    logic [XLEN-1:0] inst_nx;
    logic [XLEN-1:0] cnt_nx;
    logic            req_valid_q;

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_addr      = pc;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state and datapath update selection
    always_comb begin
        state_nx = state_q;
        pc_nx    = pc;
        inst_nx  = inst;
        cnt_nx   = fetch_cnt;
        case (state_q)
            S_REQ: begin
                if (mem.mem_req_ready) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.mem_resp_valid) begin
                    if (mem.mem_resp_err) begin
                        state_nx = S_FAULT;
                    end else begin
                        inst_nx  = mem.mem_rdata;
                        cnt_nx   = fetch_cnt + XLEN'(1);
                        state_nx = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (pc_next_valid) begin
                    pc_nx    = pc_next;
                    state_nx = (pc_next[1:0] == 2'b00) ? S_REQ : S_FAULT;
                end
            end
            S_FAULT: begin
                state_nx = S_FAULT;
            end
            default: begin
                state_nx = S_FAULT;
            end
        endcase
    end

    // Datapath registers; handshake flags are registered decodes of the next state
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            inst        <= NOP;
            fetch_cnt   <= '0;
            req_valid_q <= 1'b1;
            inst_valid  <= 1'b0;
            fault       <= 1'b0;
        end else begin
            pc          <= pc_nx;
            inst        <= inst_nx;
            fetch_cnt   <= cnt_nx;
            req_valid_q <= (state_nx == S_REQ);
            inst_valid  <= (state_nx == S_HOLD);
            fault       <= (state_nx == S_FAULT);
        end
    end
endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: reset, latency, backpressure, retire, jump, faults.
module tb_ifu;
    logic        clock;
    logic        reset_n;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pc_next_valid;
    logic [31:0] pc_next;
    logic        fault;
    logic [31:0] fetch_cnt;

    int passed;
    int total;
    int accepts;
    int req_cycles;

    ifu_if bus ();

    ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .mem           (bus),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .pc            (pc),
        .pc_next_valid (pc_next_valid),
        .pc_next       (pc_next),
        .fault         (fault),
        .fetch_cnt     (fetch_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial accepts = 0;
    always @(posedge clock) begin
        if (bus.mem_req_valid && bus.mem_req_ready) accepts = accepts + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Request accepted immediately, response after `wait_cycles` idle cycles
    task automatic fetch(input logic [31:0] data, input int wait_cycles);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        repeat (wait_cycles) tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = data;
        tick();
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic retire(input logic [31:0] target);
        pc_next_valid = 1'b1;
        pc_next       = target;
        tick();
        pc_next_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          acc0;
        passed             = 0;
        total              = 0;
        reset_n            = 1'b0;
        pc_next_valid      = 1'b0;
        pc_next            = 32'h0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_err   = 1'b0;
        bus.mem_rdata      = 32'h0;
        tick();
        tick();

        // Reset values
        check("rst_inst",      inst, 32'h0000_0013);
        check("rst_cnt",       fetch_cnt, 32'd0);
        check("rst_fault",     32'(fault), 32'd0);
        check("rst_inst_valid",32'(inst_valid), 32'd0);
        reset_n = 1'b1;

        // First fetch, best-case latency
        check("first_req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("first_addr",      bus.mem_addr, 32'h8000_0000);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        check("wait_req_low",   32'(bus.mem_req_valid), 32'd0);
        check("wait_iv_low",    32'(inst_valid), 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0050_0093;
        tick();
        bus.mem_resp_valid = 1'b0;
        check("first_iv",   32'(inst_valid), 32'd1);
        check("first_inst", inst, 32'h0050_0093);
        check("first_cnt",  fetch_cnt, 32'd1);

        // Sequential retire
        retire(32'h8000_0004);
        check("seq_req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("seq_addr",      bus.mem_addr, 32'h8000_0004);
        check("seq_iv_low",    32'(inst_valid), 32'd0);

        // Backpressure: 3 stalled cycles then accept
        acc0 = accepts;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", 32'(bus.mem_req_valid), 32'd1);
            check("bp_addr",  bus.mem_addr, 32'h8000_0004);
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        check("bp_req_low", 32'(bus.mem_req_valid), 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0000_0113;
        tick();
        bus.mem_resp_valid = 1'b0;
        check("bp_accepts", 32'(accepts - acc0), 32'd1);
        check("bp_cnt",     fetch_cnt, 32'd2);
        check("bp_inst",    inst, 32'h0000_0113);

        // Eight more sequential fetches with varying memory latency
        exp_pc = 32'h8000_0004;
        for (int i = 0; i < 8; i++) begin
            exp_pc = exp_pc + 32'd4;
            retire(exp_pc);
            fetch(32'h0000_1000 + 32'(i), i % 3);
        end
        check("seq10_cnt",  fetch_cnt, 32'd10);
        check("seq10_pc",   pc, 32'h8000_0024);
        check("seq10_inst", inst, 32'h0000_1007);

        // Jump, and pc_next_valid ignored while waiting
        retire(32'h8000_0100);
        check("jump_addr", bus.mem_addr, 32'h8000_0100);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        retire(32'h8000_0200);
        check("ign_pc",    pc, 32'h8000_0100);
        check("ign_req",   32'(bus.mem_req_valid), 32'd0);
        check("ign_iv",    32'(inst_valid), 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0640_006F;
        tick();
        bus.mem_resp_valid = 1'b0;
        check("jump_inst", inst, 32'h0640_006F);
        check("jump_pc",   pc, 32'h8000_0100);
        check("jump_cnt",  fetch_cnt, 32'd11);

        // Misaligned next PC
        retire(32'h8000_0002);
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_pc",    pc, 32'h8000_0002);
        check("mis_req",   32'(bus.mem_req_valid), 32'd0);
        check("mis_iv",    32'(inst_valid), 32'd0);
        do_reset();
        check("rst_clr_fault", 32'(fault), 32'd0);
        check("rst_clr_addr",  bus.mem_addr, 32'h8000_0000);

        // Bus error fault, then silence for 20 cycles
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_err   = 1'b1;
        bus.mem_rdata      = 32'hDEAD_BEEF;
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_err   = 1'b0;
        check("err_fault", 32'(fault), 32'd1);
        check("err_iv",    32'(inst_valid), 32'd0);
        check("err_inst",  inst, 32'h0000_0013);
        check("err_cnt",   fetch_cnt, 32'd0);
        req_cycles = 0;
        bus.mem_req_ready = 1'b1;
        pc_next_valid     = 1'b1;
        pc_next           = 32'h8000_0400;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.mem_req_valid) req_cycles = req_cycles + 1;
        end
        bus.mem_req_ready = 1'b0;
        pc_next_valid     = 1'b0;
        check("err_no_req", 32'(req_cycles), 32'd0);
        check("err_sticky", 32'(fault), 32'd1);
        check("err_pc",     pc, 32'h8000_0000);

        // Reset during S_WAIT; stale response lands in first post-reset cycle
        do_reset();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n            = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hCAFE_F00D;
        tick();
        bus.mem_resp_valid = 1'b0;
        check("stale_inst", inst, 32'h0000_0013);
        check("stale_cnt",  fetch_cnt, 32'd0);
        check("stale_req",  32'(bus.mem_req_valid), 32'd1);
        check("stale_addr", bus.mem_addr, 32'h8000_0000);
        check("stale_iv",   32'(inst_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
